// File: rtl/led_pkg.sv
// Shared LED mode encodings and sizing helpers, used by the mode controller
// and by the downstream LED pattern stage.
package led_pkg;

    localparam int MODE_W = 2;

    // Each mode names the pair of LEDs that is lit.
    typedef enum logic [MODE_W-1:0] {
        M12 = 2'd0,
        M23 = 2'd1,
        M34 = 2'd2,
        M14 = 2'd3
    } led_mode_e;

    function automatic led_mode_e next_mode(input led_mode_e m);
        case (m)
            M12:     return M23;
            M23:     return M34;
            M34:     return M14;
            default: return M12;
        endcase
    endfunction

    // Width of a counter that holds 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and debouncer for a raw push button; riseO pulses
// for one cycle together with the 0->1 edge of the debounced level.
module btn_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clkI,
    input  logic rstI,
    input  logic btnI,
    output logic lvlO,
    output logic riseO
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would chain the flops together.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvlO   <= 1'b0;
            riseO  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btnI};
            riseO  <= 1'b0;
            if (sync_q[1] == lvlO) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                lvlO  <= ~lvlO;
                riseO <= ~lvlO;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED pair mode controller: debounced button cycles through four modes and a
// tick strobe paces the pattern stage. Define LED_MODE_AUTO_EN for auto-advance.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV     = 12500000,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int AUTO_TICKS   = 8
) (
    input  logic              clkI,
    input  logic              rstI,
    input  logic              btnI,
    output logic              tickO,
    output logic [MODE_W-1:0] modeO,
    output logic              modeChgO,
    output logic              btnLvlO
);

    if (TICK_DIV < 2 || DEBOUNCE_CYC < 1 || AUTO_TICKS < 1) begin : g_bad_param
        $error("led_mode_ctrl: parameter out of range");
    end

    localparam int                TICK_W    = cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              btn_rise;
    logic              auto_fire;
    logic              mode_adv;
    led_mode_e         mode_q;
    logic [TICK_W-1:0] tick_cnt_q;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clkI (clkI),
        .rstI (rstI),
        .btnI (btnI),
        .lvlO (btnLvlO),
        .riseO(btn_rise)
    );

`ifdef LED_MODE_AUTO_EN
    localparam int                AUTO_W    = cnt_width(AUTO_TICKS);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TICKS - 1);

    logic [AUTO_W-1:0] auto_cnt_q;

    // Fires on the edge after the last tick of the idle window.
    assign auto_fire = tickO && (auto_cnt_q == AUTO_LAST);

    always_ff @(posedge clkI) begin
        if (rstI) begin
            auto_cnt_q <= '0;
        end else if (mode_adv) begin
            auto_cnt_q <= '0;
        end else if (tickO) begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // A press and an auto-advance in the same cycle still move one state.
    assign mode_adv = btn_rise | auto_fire;

    always_ff @(posedge clkI) begin
        if (rstI) begin
            mode_q     <= M12;
            modeChgO   <= 1'b0;
            tickO      <= 1'b0;
            tick_cnt_q <= TICK_LAST;
        end else begin
            modeChgO <= mode_adv;
            if (mode_adv) begin
                mode_q     <= next_mode(mode_q);
                tick_cnt_q <= TICK_LAST;
                tickO      <= 1'b0;
            end else if (tick_cnt_q == '0) begin
                tick_cnt_q <= TICK_LAST;
                tickO      <= 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q - 1'b1;
                tickO      <= 1'b0;
            end
        end
    end

    assign modeO = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: an edge-counting behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_led_mode_ctrl;
    import led_pkg::*;

    localparam int TICK_DIV     = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int AUTO_TICKS   = 2;

    logic              clkI = 1'b0;
    logic              rstI;
    logic              btnI;
    logic              tickO;
    logic [MODE_W-1:0] modeO;
    logic              modeChgO;
    logic              btnLvlO;

    int total    = 0;
    int bad      = 0;
    int chg_seen = 0;
    bit model_on = 1'b0;

    // Model state: btn samples seen one and two edges ago, debounced level,
    // run of disagreeing edges, pending press, mode, edges since tick reload,
    // ticks since last mode change, and the expected registered outputs.
    int m_s1, m_s2, m_lvl, m_run, m_rise, m_mode, m_chg, m_tick, m_since, m_auto;

    always #5 clkI = ~clkI;

    led_mode_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .AUTO_TICKS  (AUTO_TICKS)
    ) dut (
        .clkI    (clkI),
        .rstI    (rstI),
        .btnI    (btnI),
        .tickO   (tickO),
        .modeO   (modeO),
        .modeChgO(modeChgO),
        .btnLvlO (btnLvlO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit adv;
        bit prev_tick;
        if (rstI === 1'b1) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_rise = 0;
            m_mode = 0; m_chg = 0; m_tick = 0; m_since = 0; m_auto = 0;
            model_on = 1'b1;
        end else begin
            adv       = (m_rise == 1);
            prev_tick = (m_tick == 1);
`ifdef LED_MODE_AUTO_EN
            if (prev_tick && (m_auto + 1 == AUTO_TICKS)) adv = 1'b1;
`endif
            if (adv) begin
                m_mode  = (m_mode + 1) % 4;
                m_chg   = 1;
                m_tick  = 0;
                m_since = 0;
                m_auto  = 0;
            end else begin
                m_chg = 0;
                if (m_since + 1 == TICK_DIV) begin
                    m_tick  = 1;
                    m_since = 0;
                end else begin
                    m_tick = 0;
                    m_since++;
                end
`ifdef LED_MODE_AUTO_EN
                if (prev_tick) m_auto++;
`endif
            end
            m_rise = 0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == DEBOUNCE_CYC) begin
                    m_lvl  = 1 - m_lvl;
                    m_run  = 0;
                    m_rise = m_lvl;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = (btnI === 1'b1) ? 1 : 0;
        end
    endtask

    // Model advances on each rising edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge clkI);
            model_step();
            @(negedge clkI);
            if (model_on) begin
                check("model_tickO",    tickO,    m_tick);
                check("model_modeO",    modeO,    m_mode);
                check("model_modeChgO", modeChgO, m_chg);
                check("model_btnLvlO",  btnLvlO,  m_lvl);
                if (modeChgO === 1'b1) chg_seen++;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clkI);
        #1;
    endtask

    // After return, the next rising edge is edge 1 after release.
    task automatic do_reset(input logic btn_at_release);
        rstI = 1'b1;
        btnI = 1'b0;
        tick_n(2);
        rstI     = 1'b0;
        btnI     = btn_at_release;
        chg_seen = 0;
    endtask

    initial begin
        int exp_seq[4];
        exp_seq = '{1, 2, 3, 0};
        rstI = 1'b1;
        btnI = 1'b0;

        // Reset then idle.
        do_reset(1'b0);
        check("reset_modeO",   modeO,    0);
        check("reset_tickO",   tickO,    0);
        check("reset_btnLvlO", btnLvlO,  0);
        check("reset_chg",     modeChgO, 0);
`ifndef LED_MODE_AUTO_EN
        for (int e = 1; e <= 12; e++) begin
            tick_n(1);
            check("idle_tickO", tickO, (e % 4 == 0) ? 1 : 0);
        end
        check("idle_modeO", modeO, 0);
        check("idle_chg_count", chg_seen, 0);
`endif

        // Button high from edge 1 and held.
        do_reset(1'b1);
        tick_n(4);
        check("press_lvl_e4",  btnLvlO, 0);
        check("press_tick_e4", tickO,   1);
        tick_n(1);
        check("press_lvl_e5",  btnLvlO, 1);
        check("press_mode_e5", modeO,   0);
        tick_n(1);
        check("press_mode_e6", modeO,    1);
        check("press_chg_e6",  modeChgO, 1);
        tick_n(1);
        check("press_chg_e7",  modeChgO, 0);
        tick_n(1);
        check("press_tick_e8", tickO, 0);
        tick_n(2);
        check("press_tick_e10", tickO, 1);
        btnI = 1'b0;
        tick_n(8);
        check("release_lvl", btnLvlO, 0);
`ifndef LED_MODE_AUTO_EN
        check("release_mode", modeO, 1);
`endif

        // Glitch two cycles wide.
        do_reset(1'b0);
        tick_n(2);
        btnI = 1'b1;
        tick_n(2);
        btnI = 1'b0;
        tick_n(4);
        check("glitch_lvl", btnLvlO, 0);
`ifndef LED_MODE_AUTO_EN
        check("glitch_mode", modeO, 0);
        check("glitch_chg_count", chg_seen, 0);
`endif

        // Four clean presses, including the wrap.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            btnI = 1'b1;
            tick_n(6);
            btnI = 1'b0;
            tick_n(6);
`ifndef LED_MODE_AUTO_EN
            check("presses_mode", modeO, exp_seq[i]);
`endif
        end
`ifndef LED_MODE_AUTO_EN
        check("presses_chg_count", chg_seen, 4);
`endif

`ifdef LED_MODE_AUTO_EN
        // Auto-advance, then a press landing on the second auto fire.
        do_reset(1'b0);
        tick_n(8);
        check("auto_mode_e8", modeO, 0);
        tick_n(1);
        check("auto_mode_e9", modeO,    1);
        check("auto_chg_e9",  modeChgO, 1);
        tick_n(3);
        btnI = 1'b1;
        tick_n(5);
        check("coinc_mode_e17", modeO,   1);
        check("coinc_lvl_e17",  btnLvlO, 1);
        tick_n(1);
        check("coinc_mode_e18", modeO,    2);
        check("coinc_chg_e18",  modeChgO, 1);
        tick_n(1);
        check("coinc_chg_e19",  modeChgO, 0);
        check("coinc_mode_e19", modeO,    2);
        btnI = 1'b0;
        tick_n(6);
`endif

        // Reset asserted mid-debounce.
        do_reset(1'b1);
        tick_n(3);
        rstI = 1'b1;
        btnI = 1'b0;
        tick_n(1);
        check("midrst_modeO",   modeO,    0);
        check("midrst_tickO",   tickO,    0);
        check("midrst_chg",     modeChgO, 0);
        check("midrst_btnLvlO", btnLvlO,  0);
        tick_n(1);
        rstI     = 1'b0;
        chg_seen = 0;
        tick_n(8);
        check("midrst_after_chg_count", chg_seen, 0);
        check("midrst_after_lvl",       btnLvlO,  0);
        check("midrst_after_mode",      modeO,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12500000: clkI cycles per tick period (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 250000: consecutive stable cycles needed to accept a button level (>=1).
REQ-003 SHALL have parameter AUTO_TICKS, default 8: ticks without a mode change before auto-advance (>=1, used only with LED_MODE_AUTO_EN).
REQ-004 SHALL have port clkI  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rstI  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port btnI  input  1  raw asynchronous push button, active-high (pressed = 1).
REQ-007 SHALL have port tickO  output  1  one-cycle tick pulse strobing the downstream LED pattern stage.
REQ-008 SHALL have port modeO  output  2  LED pair select: 0 = LEDs 1/2, 1 = LEDs 2/3, 2 = LEDs 3/4, 3 = LEDs 1/4.
REQ-009 SHALL have port modeChgO  output  1  one-cycle pulse, high in the same cycle modeO first shows a new value.
REQ-010 SHALL have port btnLvlO  output  1  debounced button level.

Function
REQ-011 SHALL pass btnI through a 2-flop synchronizer before any other use.
REQ-012 SHALL run a debounce counter that clears when the synchronized level equals btnLvlO and increments while they differ; when it equals DEBOUNCE_CYC-1 and the levels still differ, btnLvlO SHALL toggle and the counter SHALL clear.
REQ-013 SHALL treat a 0->1 transition of btnLvlO as a press; releases SHALL NOT advance the mode.
REQ-014 SHALL hold a 4-state mode FSM M12(0) -> M23(1) -> M34(2) -> M14(3) -> M12; each press advances one state one edge after btnLvlO rises, giving DEBOUNCE_CYC+3 edges from the first edge sampling btnI high.
REQ-015 SHALL wrap M14 to M12 with no extra or skipped state.
REQ-016 SHALL run a tick down-counter reloaded to TICK_DIV-1; at the edge where it is 0 it SHALL reload and register tickO=1, otherwise tickO=0, for a period of exactly TICK_DIV cycles.
REQ-017 SHALL reload the tick counter to TICK_DIV-1 and force tickO=0 on any mode change; a mode change SHALL win over a coincident tick.
REQ-018 SHALL assert modeChgO for exactly one cycle per mode advance.
REQ-019 SHALL ignore button glitches shorter than DEBOUNCE_CYC cycles with no output change.

Reset
REQ-020 SHALL, while rstI is high at a clock edge, set modeO=0, tickO=0, modeChgO=0, btnLvlO=0, synchronizer flops=0, debounce counter=0, auto counter=0, and tick counter=TICK_DIV-1.
REQ-021 SHALL abandon any debounce, tick or auto count in progress on mid-operation reset, with no press or tick pending afterwards.
REQ-022 SHALL NOT report a press if btnI is held high through reset release until DEBOUNCE_CYC stability completes (btnLvlO starts at 0, so one press then follows).

Configuration
REQ-023 SHALL, with LED_MODE_AUTO_EN defined, count tickO pulses since the last mode change and auto-advance the FSM on the edge after the AUTO_TICKS-th tick, asserting modeChgO; any mode change SHALL clear this count.
REQ-024 SHALL advance exactly one state when a press and an auto-advance fall in the same cycle.
REQ-025 SHALL, without LED_MODE_AUTO_EN, change mode only on presses, with no auto counter logic synthesized.

Structure
REQ-026 SHALL define the mode encodings (M12/M23/M34/M14) and the 2-bit mode width in shared package led_pkg, which the LED pattern stage also uses.
REQ-027 SHALL place the synchronizer and debounce logic in sub-module btn_debounce (ports clkI, rstI, btnI, lvlO, riseO).

Verification
REQ-028 SHALL use bench parameters TICK_DIV=4, DEBOUNCE_CYC=3, AUTO_TICKS=2 for all scenarios below.
REQ-029 SHALL check reset then idle -> tickO high on edges 4, 8 and 12 after release, modeO=0, modeChgO never high.
REQ-030 SHALL check btnI high at edge 1 and held -> btnLvlO=1 at edge 5, modeO=1 and modeChgO=1 at edge 6, tick counter restarted.
REQ-031 SHALL check a 2-cycle btnI pulse -> btnLvlO, modeO and modeChgO unchanged.
REQ-032 SHALL check four clean presses -> modeO sequence 1, 2, 3, 0, with exactly four modeChgO pulses.
REQ-033 SHALL check, with LED_MODE_AUTO_EN, idle after reset -> modeO=1 one edge after the 2nd tickO; a press coincident with the auto fire -> modeO advances by exactly one.
REQ-034 SHALL check rstI asserted mid-debounce (sync level high, counter=1) -> all outputs at reset values, no modeChgO after release.
